// File: rtl/decode_pkg.sv
// decode_pkg: immediate format codes and RV32I/RV64I base opcodes used by the decode stage
package decode_pkg;
  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
endpackage

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: combinational opcode to immediate/format/alu-op/illegal mapping
`include "processor_defines.sv"
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction_code,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        imm_fmt,
  output logic [4:0]      alu_control,
  output logic            illegal
);
  logic [31:0] i;
  logic [6:0] op;
  assign i = instruction_code;
  assign op = i[6:0];
  always_comb begin
    imm_fmt = (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
              (op == OP_JAL) ? FMT_J :
              (op == OP_JALR || op == OP_IMM || op == OP_LOAD) ? FMT_I :
              (op == OP_STORE) ? FMT_S :
              (op == OP_BRANCH) ? FMT_B : FMT_NONE;
    imm = (imm_fmt == FMT_I) ? {{(XLEN-11){i[31]}}, i[30:20]} :
          (imm_fmt == FMT_S) ? {{(XLEN-11){i[31]}}, i[30:25], i[11:7]} :
          (imm_fmt == FMT_B) ? {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
          (imm_fmt == FMT_U) ? {{(XLEN-31){i[31]}}, i[30:12], 12'b0} :
          (imm_fmt == FMT_J) ? {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0} : '0;
    alu_control = (op == OP_LUI) ? `LUI : (op == OP_AUIPC) ? `AUIPC : `ALU_NOP;
    illegal = imm_fmt == FMT_NONE;
  end
endmodule

// File: rtl/processor_defines.sv
// processor_defines: ALU operation codes shared across the front end
`ifndef PROCESSOR_DEFINES_SV
`define PROCESSOR_DEFINES_SV
`define ALU_NOP 5'b00000
`define LUI     5'b01101
`define AUIPC   5'b01110
`endif

// File: rtl/decode_imm_stage.sv
// decode_imm_stage: registered immediate decode with valid/ready handshake; DECODE_SKID_EN adds a one-entry skid
`include "processor_defines.sv"
module decode_imm_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction_code,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_fmt,
  output logic [4:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);
  localparam int W = 3*XLEN + 14;
  localparam logic [W-1:0] rst_d = {5'd0, {XLEN{1'b0}}, FMT_NONE, `ALU_NOP, {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b0};
  logic [XLEN-1:0] g_imm, g_res;
  imm_fmt_e g_fmt;
  logic [4:0] g_alu;
  logic g_ill, in_fire;
  logic [6:0] op;
  logic [W-1:0] d_new, d_q;
  decode_imm_gen #(.XLEN(XLEN)) u_gen (
    .instruction_code(instruction_code),
    .imm(g_imm),
    .imm_fmt(g_fmt),
    .alu_control(g_alu),
    .illegal(g_ill)
  );
  assign op = instruction_code[6:0];
  assign g_res = (op == OP_LUI) ? g_imm : (op == OP_AUIPC || op == OP_JAL) ? pc + g_imm : '0;
  assign d_new = {instruction_code[11:7], g_imm, g_fmt, g_alu, g_res, pc, g_ill};
  assign {rd, imm, imm_fmt, alu_control, result, pc_out, illegal} = d_q;
`ifdef DECODE_SKID_EN
  logic skid_valid;
  logic [W-1:0] d_skid;
  // in_ready comes only from the skid flop, so out_ready never reaches it combinationally
  assign in_ready = !skid_valid;
  assign in_fire = in_valid && !skid_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      d_q <= rst_d;
      skid_valid <= 1'b0;
      d_skid <= rst_d;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= skid_valid || in_fire;
      if (skid_valid) begin
        d_q <= d_skid;
        skid_valid <= 1'b0;
      end else if (in_fire)
        d_q <= d_new;
    end else if (in_fire) begin
      d_skid <= d_new;
      skid_valid <= 1'b1;
    end
`else
  assign in_ready = !out_valid || out_ready;
  assign in_fire = in_valid && in_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      d_q <= rst_d;
    end else if (flush)
      out_valid <= 1'b0;
    else if (in_fire) begin
      out_valid <= 1'b1;
      d_q <= d_new;
    end else if (out_ready)
      out_valid <= 1'b0;
`endif
endmodule
